// File: rtl/spi_mnrch_burst_if.sv
// spi_mnrch_burst_if: command strobe, word data and SPI pin bundle for spi_mnrch_burst
interface spi_mnrch_burst_if #(
  parameter int WIDTH = 16,
  parameter int MAX_BURST = 8
);
  localparam int LW = $clog2(MAX_BURST + 1);
  logic wrt;
  logic [LW-1:0] len;
  logic [WIDTH-1:0] wt_data;
  logic [WIDTH-1:0] rd_data;
  logic rd_vld;
  logic wrd_start;
  logic done;
  logic busy;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  modport master (
    input wrt, len, wt_data, MISO,
    output SS_n, SCLK, MOSI, rd_data, rd_vld, wrd_start, done, busy
  );
  modport slave (
    output wrt, len, wt_data, MISO,
    input SS_n, SCLK, MOSI, rd_data, rd_vld, wrd_start, done, busy
  );
endinterface

// File: rtl/spi_mnrch_burst.sv
// spi_mnrch_burst: SPI monarch with configurable word width, SCLK divider and multi-word burst frames
module spi_mnrch_burst #(
  parameter int WIDTH = 16,
  parameter int SCLK_DIV = 32,
  parameter int MAX_BURST = 8
) (
  input logic clk,
  input logic rst_n,
  spi_mnrch_burst_if.master bus
);
  localparam int LW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_RISE = CW'(SCLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FRONT = CW'(3 * SCLK_DIV / 4);
  typedef enum logic [1:0] {IDLE, FRONT, SHIFT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [WIDTH-1:0] shft_q, shft_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic smpl_q, smpl_d;
  logic rd_vld_q, rd_vld_d;
  logic wrd_start_q, wrd_start_d;
  logic done_q, done_d;
  logic start, rise, wrap, bnd;
  always_comb begin
    start = bus.wrt && bus.len != '0 && bus.len <= LW'(MAX_BURST);
    rise = cnt_q == CNT_RISE;
    wrap = cnt_q == CNT_LAST;
    bnd = state_q == SHIFT && wrap && bcnt_q == BW'(WIDTH);
    state_d = state_q;
    cnt_d = state_q == IDLE ? CNT_FRONT : cnt_q + 1'b1;
    bcnt_d = bcnt_q;
    wcnt_d = wcnt_q;
    shft_d = shft_q;
    smpl_d = smpl_q;
    rd_data_d = rd_data_q;
    rd_vld_d = 1'b0;
    wrd_start_d = 1'b0;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = FRONT;
      shft_d = bus.wt_data;
      wcnt_d = bus.len;
      bcnt_d = '0;
    end
    if (state_q == FRONT && wrap)
      state_d = SHIFT;
    if (state_q == SHIFT) begin
      if (rise) begin
        smpl_d = bus.MISO;
        bcnt_d = bcnt_q + 1'b1;
      end
      if (wrap && bcnt_q < BW'(WIDTH))
        shft_d = {shft_q[WIDTH-2:0], smpl_q};
      if (bnd) begin
        rd_data_d = {shft_q[WIDTH-2:0], smpl_q};
        rd_vld_d = 1'b1;
        bcnt_d = '0;
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q > LW'(1)) begin
          shft_d = bus.wt_data;
          wrd_start_d = 1'b1;
        end else begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bcnt_q <= '0;
      wcnt_q <= '0;
      shft_q <= '0;
      smpl_q <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q <= 1'b0;
      wrd_start_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bcnt_q <= bcnt_d;
      wcnt_q <= wcnt_d;
      shft_q <= shft_d;
      smpl_q <= smpl_d;
      rd_data_q <= rd_data_d;
      rd_vld_q <= rd_vld_d;
      wrd_start_q <= wrd_start_d;
      done_q <= done_d;
    end
  end
  assign bus.SS_n = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.SCLK = state_q == SHIFT ? cnt_q[CW-1] : 1'b1;
  assign bus.MOSI = shft_q[WIDTH-1];
  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld = rd_vld_q;
  assign bus.wrd_start = wrd_start_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_spi_mnrch_burst.sv
// tb_spi_mnrch_burst: table-driven frame vectors plus reset and protocol checks for spi_mnrch_burst
module tb_spi_mnrch_burst;
  typedef struct packed {
    logic sel;
    logic loop;
    logic [3:0] len;
    logic [15:0] rewrt;
    logic [7:0][15:0] w;
    logic [7:0][15:0] e;
    logic [15:0] ss;
    logic [7:0] rises;
  } vec_t;
  localparam int NV = 9;
  localparam logic [15:0] RESP [3] = '{16'h00C5, 16'h1234, 16'hBEEF};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wrt = 1'b0;
  logic [3:0] len = '0;
  logic [15:0] wdat = '0;
  logic sel = 1'b0;
  logic loop = 1'b1;
  int n_vec = 0;
  int n_miss = 0;
  vec_t tbl [NV];
  always #5 clk = ~clk;
  spi_mnrch_burst_if #(.WIDTH(16), .MAX_BURST(8)) ifa ();
  spi_mnrch_burst_if #(.WIDTH(8), .MAX_BURST(8)) ifb ();
  spi_mnrch_burst #(.WIDTH(16), .SCLK_DIV(32), .MAX_BURST(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
  spi_mnrch_burst #(.WIDTH(8), .SCLK_DIV(8), .MAX_BURST(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));
  logic [15:0] sens_sh = 16'h0;
  int sens_rises = 0;
  logic sens_sp = 1'b1;
  always @(posedge clk) begin
    sens_sp <= ifa.SCLK;
    if (ifa.SS_n) begin
      sens_rises <= 0;
      sens_sh <= RESP[0];
    end else begin
      if (ifa.SCLK && !sens_sp) sens_rises <= sens_rises + 1;
      if (!ifa.SCLK && sens_sp && sens_rises > 0)
        sens_sh <= (sens_rises % 16 == 0) ? RESP[(sens_rises / 16) % 3] : {sens_sh[14:0], 1'b0};
    end
  end
  assign ifa.wrt = wrt & ~sel;
  assign ifb.wrt = wrt & sel;
  assign ifa.len = len;
  assign ifb.len = len;
  assign ifa.wt_data = wdat;
  assign ifb.wt_data = wdat[7:0];
  assign ifa.MISO = loop ? ifa.MOSI : sens_sh[15];
  assign ifb.MISO = ifb.MOSI;
  logic ss_n, sclk, mosi, rvld, wst, dn, bsy;
  logic [15:0] rdat;
  always_comb begin
    ss_n = sel ? ifb.SS_n : ifa.SS_n;
    sclk = sel ? ifb.SCLK : ifa.SCLK;
    mosi = sel ? ifb.MOSI : ifa.MOSI;
    rvld = sel ? ifb.rd_vld : ifa.rd_vld;
    wst = sel ? ifb.wrd_start : ifa.wrd_start;
    dn = sel ? ifb.done : ifa.done;
    bsy = sel ? ifb.busy : ifa.busy;
    rdat = sel ? {8'h00, ifb.rd_data} : ifa.rd_data;
  end
  logic a_sp = 1'b1, a_mp = 1'b0, b_sp = 1'b1, b_mp = 1'b0;
  int a_gap = 100, b_gap = 100, a_err = 0, b_err = 0;
  always @(negedge clk) begin
    a_sp <= ifa.SCLK;
    a_mp <= ifa.MOSI;
    a_gap <= (ifa.SCLK != a_sp) ? 1 : a_gap + 1;
    if (ifa.SCLK != a_sp && (ifa.SS_n || a_gap < 16 || (ifa.SCLK && ifa.MOSI != a_mp))) begin
      a_err <= a_err + 1;
      $display("FAIL proto_a: SCLK edge with SS_n=%b gap=%0d (required >=16) MOSI %b->%b", ifa.SS_n, a_gap, a_mp, ifa.MOSI);
    end
  end
  always @(negedge clk) begin
    b_sp <= ifb.SCLK;
    b_mp <= ifb.MOSI;
    b_gap <= (ifb.SCLK != b_sp) ? 1 : b_gap + 1;
    if (ifb.SCLK != b_sp && (ifb.SS_n || b_gap < 4 || (ifb.SCLK && ifb.MOSI != b_mp))) begin
      b_err <= b_err + 1;
      $display("FAIL proto_b: SCLK edge with SS_n=%b gap=%0d (required >=4) MOSI %b->%b", ifb.SS_n, b_gap, b_mp, ifb.MOSI);
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic s, input logic l, input logic [3:0] n, input int rw,
                              input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                              input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                              input int ss, input int rs);
    vec_t v = '0;
    v.sel = s;
    v.loop = l;
    v.len = n;
    v.rewrt = 16'(rw);
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.e[0] = e0;
    v.e[1] = e1;
    v.e[2] = e2;
    v.ss = 16'(ss);
    v.rises = 8'(rs);
    return v;
  endfunction
  task automatic run_frame(input int id, input vec_t v);
    int ss_low = 0, rises = 0, nvld = 0, nws = 0, first_fall = -1, last_rise = 0, bad = 0;
    int half = v.sel ? 4 : 16;
    int quart = v.sel ? 2 : 8;
    logic sp = 1'b1;
    bit fin = 0;
    sel = v.sel;
    loop = v.loop;
    @(negedge clk);
    wrt = 1'b1;
    len = v.len;
    wdat = v.w[0];
    @(negedge clk);
    wrt = 1'b0;
    wdat = v.w[1];
    if (v.ss == 0) begin
      for (int c = 0; c < 100; c++) begin
        if (!ss_n || bsy || dn) bad++;
        @(negedge clk);
      end
      check($sformatf("v%0d_ignored_start", id), bad, 0);
      return;
    end
    check($sformatf("v%0d_ss_fall", id), ss_n, 0);
    check($sformatf("v%0d_busy_up", id), bsy, 1);
    for (int c = 0; c < 6000 && !fin; c++) begin
      wrt = v.rewrt != 0 && c == int'(v.rewrt);
      if (!ss_n) ss_low++;
      if (sclk != sp) begin
        if (sclk) begin
          rises++;
          last_rise = c;
        end else if (first_fall < 0) first_fall = c;
      end
      sp = sclk;
      if (rvld) begin
        check($sformatf("v%0d_rd%0d", id, nvld), rdat, v.e[nvld[2:0]]);
        nvld++;
      end
      if (wst) begin
        check($sformatf("v%0d_ws_with_vld", id), rvld, 1);
        nws++;
        if (nws < 7) wdat = v.w[nws + 1];
      end
      if (dn) begin
        fin = 1;
        check($sformatf("v%0d_done_ss_rise", id), ss_n, 1);
        check($sformatf("v%0d_done_busy", id), bsy, 0);
        check($sformatf("v%0d_done_vld", id), rvld, 1);
        check($sformatf("v%0d_back_porch", id), c - last_rise, half);
      end
      if (!fin) @(negedge clk);
    end
    wrt = 1'b0;
    check($sformatf("v%0d_done_seen", id), fin, 1);
    check($sformatf("v%0d_ss_low", id), ss_low, v.ss);
    check($sformatf("v%0d_rises", id), rises, v.rises);
    check($sformatf("v%0d_first_fall", id), first_fall, quart);
    check($sformatf("v%0d_nvld", id), nvld, v.len);
    check($sformatf("v%0d_nws", id), nws, v.len - 1);
    @(negedge clk);
    check($sformatf("v%0d_done_1cyc", id), dn, 0);
    check($sformatf("v%0d_ss_idle", id), ss_n, 1);
  endtask
  initial begin
    int r, dns;
    logic sp;
    tbl[0] = mk(0, 1, 1, 0, 16'hA5C3, 16'h0, 16'h0, 16'hA5C3, 16'h0, 16'h0, 520, 16);
    tbl[1] = mk(0, 0, 3, 0, 16'hA200, 16'h0000, 16'h0000, 16'h00C5, 16'h1234, 16'hBEEF, 1544, 48);
    tbl[2] = mk(1, 1, 2, 0, 16'h003C, 16'h00F0, 16'h0, 16'h003C, 16'h00F0, 16'h0, 130, 16);
    tbl[3] = mk(0, 1, 8, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4104, 128);
    for (int k = 0; k < 8; k++) begin
      tbl[3].w[k] = 16'h1357 ^ (16'(k) * 16'h2111);
      tbl[3].e[k] = 16'h1357 ^ (16'(k) * 16'h2111);
    end
    tbl[4] = mk(0, 1, 0, 0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0);
    tbl[5] = mk(0, 1, 9, 0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0);
    tbl[6] = mk(0, 1, 1, 100, 16'h8001, 16'h0, 16'h0, 16'h8001, 16'h0, 16'h0, 520, 16);
    tbl[7] = mk(1, 1, 1, 20, 16'h00A5, 16'h0, 16'h0, 16'h00A5, 16'h0, 16'h0, 66, 8);
    tbl[8] = mk(0, 1, 2, 0, 16'hFFFF, 16'h0000, 16'h0, 16'hFFFF, 16'h0000, 16'h0, 1032, 32);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check($sformatf("rst%0d_ss_n", s), ss_n, 1);
      check($sformatf("rst%0d_sclk", s), sclk, 1);
      check($sformatf("rst%0d_mosi", s), mosi, 0);
      check($sformatf("rst%0d_rd_data", s), rdat, 0);
      check($sformatf("rst%0d_rd_vld", s), rvld, 0);
      check($sformatf("rst%0d_wrd_start", s), wst, 0);
      check($sformatf("rst%0d_done", s), dn, 0);
      check($sformatf("rst%0d_busy", s), bsy, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) run_frame(i, tbl[i]);
    sel = 1'b0;
    loop = 1'b1;
    @(negedge clk);
    wrt = 1'b1;
    len = 4'd1;
    wdat = 16'h5A5A;
    @(negedge clk);
    wrt = 1'b0;
    r = 0;
    sp = 1'b1;
    for (int c = 0; c < 2000 && r < 5; c++) begin
      @(negedge clk);
      if (sclk && !sp) r++;
      sp = sclk;
    end
    check("mid_rises_before_rst", r, 5);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ss_n", ss_n, 1);
    check("mid_rst_sclk", sclk, 1);
    check("mid_rst_busy", bsy, 0);
    check("mid_rst_mosi", mosi, 0);
    check("mid_rst_rd_data", rdat, 0);
    dns = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      if (dn || rvld || !ss_n) dns++;
    end
    check("mid_rst_no_done", dns, 0);
    run_frame(99, tbl[0]);
    check("protocol", a_err + b_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
